vga_draw_sequencer: RTL and testbench



---
 rtl/vga_draw_sequencer.sv | 169 ++++++++++++++++
 tb/tb_vga_draw_sequencer.sv | 458 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_draw_sequencer.sv
// Shares the VGA plot port between the screen-fill and circle engines: clears the
// screen after reset, then runs queued circle commands one at a time.
module vga_draw_sequencer #(
   parameter int QDEPTH = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [7:0] cmd_cx,
   input  logic [6:0] cmd_cy,
   input  logic [7:0] cmd_r,
   input  logic [2:0] cmd_colour,
   input  logic       clear_req,
   output logic       busy,
   output logic [7:0] jobs_done,
   output logic       fill_start,
   input  logic       fill_done,
   input  logic [7:0] fill_x,
   input  logic [6:0] fill_y,
   input  logic [2:0] fill_colour,
   input  logic       fill_plot,
   output logic       circ_start,
   output logic [7:0] circ_cx,
   output logic [6:0] circ_cy,
   output logic [7:0] circ_r,
   output logic [2:0] circ_colour,
   input  logic       circ_done,
   input  logic [7:0] circ_x,
   input  logic [6:0] circ_y,
   input  logic [2:0] circ_pix_colour,
   input  logic       circ_plot,
   output logic [7:0] VGA_X,
   output logic [6:0] VGA_Y,
   output logic [2:0] VGA_COLOUR,
   output logic       VGA_PLOT
);

   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0] FULL_CNT = QDEPTH[AW:0];

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      CLEAR_ACK,
      DRAW,
      DRAW_ACK
   } state_t;

   typedef struct packed {
      logic [7:0] cx;
      logic [6:0] cy;
      logic [7:0] r;
      logic [2:0] colour;
   } job_t;

   state_t        state, state_nx;
   logic          clear_pend;
   logic          start_clear;
   logic          push, pop, full, empty;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   job_t          fifo_mem [QDEPTH];
   job_t          cmd_job, head_job;

   assign cmd_job   = {cmd_cx, cmd_cy, cmd_r, cmd_colour};
   assign head_job  = fifo_mem[rd_ptr];
   assign full      = (count == FULL_CNT);
   assign empty     = (count == '0);
   assign cmd_ready = !full;
   assign push      = cmd_valid && !full;
   assign busy      = (state != IDLE) || !empty || clear_pend;

   // NOTE: every output of this block gets a default first, so no path through
   // the case statement can leave a signal unassigned and infer a latch.
   always_comb begin
      state_nx    = state;
      pop         = 1'b0;
      start_clear = 1'b0;
      fill_start  = 1'b0;
      circ_start  = 1'b0;
      VGA_X       = '0;
      VGA_Y       = '0;
      VGA_COLOUR  = '0;
      VGA_PLOT    = 1'b0;
      case (state)
         IDLE: begin
            // A pending clear always wins over queued circles.
            if (clear_pend) begin
               start_clear = 1'b1;
               state_nx    = CLEAR;
            end else if (!empty) begin
               pop      = 1'b1;
               state_nx = DRAW;
            end
         end
         CLEAR: begin
            fill_start = 1'b1;
            VGA_X      = fill_x;
            VGA_Y      = fill_y;
            VGA_COLOUR = fill_colour;
            VGA_PLOT   = fill_plot;
            if (fill_done) state_nx = CLEAR_ACK;
         end
         CLEAR_ACK: begin
            if (!fill_done) state_nx = IDLE;
         end
         DRAW: begin
            circ_start = 1'b1;
            VGA_X      = circ_x;
            VGA_Y      = circ_y;
            VGA_COLOUR = circ_pix_colour;
            VGA_PLOT   = circ_plot;
            if (circ_done) state_nx = DRAW_ACK;
         end
         DRAW_ACK: begin
            if (!circ_done) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every flop samples
   // the pre-edge values, regardless of the order the always blocks are evaluated.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the command storage is deliberately left without reset; entries are
   // only ever read behind the reset-cleared pointers and count.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr] <= cmd_job;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         clear_pend  <= 1'b1;
         circ_cx     <= '0;
         circ_cy     <= '0;
         circ_r      <= '0;
         circ_colour <= '0;
         jobs_done   <= '0;
      end else begin
         // A request landing on the edge that launches a clear is absorbed by it.
         if (start_clear)    clear_pend <= 1'b0;
         else if (clear_req) clear_pend <= 1'b1;
         if (pop) {circ_cx, circ_cy, circ_r, circ_colour} <= head_job;
         if (state == DRAW && circ_done) jobs_done <= jobs_done + 8'd1;
      end
   end

endmodule

// File: tb/tb_vga_draw_sequencer.sv
// Self-checking bench for vga_draw_sequencer: behavioural fill/circle engines,
// a command scoreboard, and a plot-bus monitor.
module tb_vga_draw_sequencer;

   localparam int QDEPTH = 4;

   typedef struct packed {
      logic [7:0] cx;
      logic [6:0] cy;
      logic [7:0] r;
      logic [2:0] colour;
   } job_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_cx;
   logic [6:0] cmd_cy;
   logic [7:0] cmd_r;
   logic [2:0] cmd_colour;
   logic       clear_req;
   logic       busy;
   logic [7:0] jobs_done;
   logic       fill_start, fill_done, fill_plot;
   logic [7:0] fill_x;
   logic [6:0] fill_y;
   logic [2:0] fill_colour;
   logic       circ_start, circ_done, circ_plot;
   logic [7:0] circ_cx, circ_r, circ_x;
   logic [6:0] circ_cy, circ_y;
   logic [2:0] circ_colour, circ_pix_colour;
   logic [7:0] VGA_X;
   logic [6:0] VGA_Y;
   logic [2:0] VGA_COLOUR;
   logic       VGA_PLOT;

   int         n_cmp = 0;
   int         n_err = 0;
   int         mon_fails = 0;
   bit         mon_en = 1'b0;
   bit         prev_fill = 1'b0, prev_circ = 1'b0;
   string      seq = "";
   job_t       exp_q[$];
   logic [7:0] exp_jobs = 8'd0;
   int         fill_len = 19200;
   int         circ_len = 4;
   bit         circ_stall = 1'b0;

   vga_draw_sequencer #(.QDEPTH(QDEPTH)) dut (
      .clk(clk), .rst(rst),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_cx(cmd_cx), .cmd_cy(cmd_cy), .cmd_r(cmd_r), .cmd_colour(cmd_colour),
      .clear_req(clear_req), .busy(busy), .jobs_done(jobs_done),
      .fill_start(fill_start), .fill_done(fill_done),
      .fill_x(fill_x), .fill_y(fill_y), .fill_colour(fill_colour), .fill_plot(fill_plot),
      .circ_start(circ_start),
      .circ_cx(circ_cx), .circ_cy(circ_cy), .circ_r(circ_r), .circ_colour(circ_colour),
      .circ_done(circ_done),
      .circ_x(circ_x), .circ_y(circ_y), .circ_pix_colour(circ_pix_colour), .circ_plot(circ_plot),
      .VGA_X(VGA_X), .VGA_Y(VGA_Y), .VGA_COLOUR(VGA_COLOUR), .VGA_PLOT(VGA_PLOT)
   );

   always #5 clk = ~clk;

   // Fill engine: plots fill_len pixels once started, then done until start drops.
   // While idle it drives random junk so a leaking mux is visible.
   initial begin
      int fill_cnt;
      fill_cnt = 0;
      fill_done = 1'b0; fill_plot = 1'b0; fill_x = '0; fill_y = '0; fill_colour = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            fill_done = 1'b0; fill_plot = 1'b0; fill_cnt = 0;
         end else if (fill_start && !fill_done) begin
            if (fill_cnt < fill_len) begin
               fill_plot = 1'b1; fill_x = 8'($urandom); fill_y = 7'($urandom);
               fill_colour = 3'($urandom); fill_cnt++;
            end else begin
               fill_plot = 1'b0; fill_done = 1'b1;
            end
         end else if (!fill_start && fill_done) begin
            fill_done = 1'b0; fill_cnt = 0;
         end else begin
            fill_plot = 1'($urandom); fill_x = 8'($urandom); fill_y = 7'($urandom);
            fill_colour = 3'($urandom);
         end
      end
   end

   // Circle engine: checks each job it is handed against the command queue, plots
   // circ_len pixels, then raises done unless stalled.
   initial begin
      int   circ_cnt;
      bit   circ_active;
      job_t got, want;
      circ_cnt = 0; circ_active = 1'b0;
      circ_done = 1'b0; circ_plot = 1'b0; circ_x = '0; circ_y = '0; circ_pix_colour = '0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            circ_done = 1'b0; circ_plot = 1'b0; circ_cnt = 0; circ_active = 1'b0;
         end else if (circ_start && !circ_done) begin
            if (!circ_active) begin
               circ_active = 1'b1; circ_cnt = 0;
               got = {circ_cx, circ_cy, circ_r, circ_colour};
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_err++;
                  $display("FAIL circ_job: got job %h, expected no job queued", got);
               end else begin
                  want = exp_q.pop_front();
                  if (got !== want) begin
                     n_err++;
                     $display("FAIL circ_job: got job %h, expected %h", got, want);
                  end
               end
            end
            if (circ_cnt < circ_len) begin
               circ_plot = 1'b1; circ_x = 8'($urandom); circ_y = 7'($urandom);
               circ_pix_colour = 3'($urandom); circ_cnt++;
            end else begin
               circ_plot = 1'b0;
               if (!circ_stall) circ_done = 1'b1;
            end
         end else if (!circ_start && circ_done) begin
            circ_done = 1'b0; circ_active = 1'b0;
         end else begin
            circ_plot = 1'($urandom); circ_x = 8'($urandom); circ_y = 7'($urandom);
            circ_pix_colour = 3'($urandom);
         end
      end
   end

   // Plot-bus monitor: VGA must follow whichever engine is started, else be zero.
   always @(posedge clk) begin
      logic [18:0] exp_bus;
      #2;
      if (mon_en) begin
         if (fill_start)      exp_bus = {fill_x, fill_y, fill_colour, fill_plot};
         else if (circ_start) exp_bus = {circ_x, circ_y, circ_pix_colour, circ_plot};
         else                 exp_bus = '0;
         n_cmp++;
         if ({VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT} !== exp_bus || (fill_start && circ_start)) begin
            n_err++;
            if (mon_fails < 10)
               $display("FAIL vga_mux @%0t: got %h (fs=%b cs=%b), expected %h",
                        $time, {VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT}, fill_start, circ_start, exp_bus);
            mon_fails++;
         end
         if (fill_start && !prev_fill) seq = {seq, "F"};
         if (circ_start && !prev_circ) seq = {seq, "C"};
      end
      prev_fill = fill_start;
      prev_circ = circ_start;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
      $fatal(1, "watchdog expired");
   end

   function automatic job_t rand_job();
      job_t j;
      j.cx = 8'($urandom); j.cy = 7'($urandom); j.r = 8'($urandom); j.colour = 3'($urandom);
      return j;
   endfunction

   // Presents one command for a cycle; readiness is predicted from the queue model.
   task automatic push_cmd(input job_t j);
      bit exp_rdy;
      @(negedge clk);
      cmd_valid = 1'b1;
      {cmd_cx, cmd_cy, cmd_r, cmd_colour} = j;
      exp_rdy = (exp_q.size() < QDEPTH);
      n_cmp++;
      if (cmd_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL cmd_ready: got %b, expected %b (queued %0d)", cmd_ready, exp_rdy, exp_q.size());
      end
      if (exp_rdy) begin
         exp_q.push_back(j);
         exp_jobs++;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k;
      for (k = 0; k < budget; k++) begin
         @(negedge clk);
         if (!busy) break;
      end
      n_cmp++;
      if (k == budget) begin
         n_err++;
         $display("FAIL %s: busy still 1 after %0d cycles, expected 0", tag, budget);
      end
   endtask

   task automatic wait_circ_start(input string tag);
      int k;
      for (k = 0; k < 100; k++) begin
         @(negedge clk);
         if (circ_start) break;
      end
      n_cmp++;
      if (k == 100) begin
         n_err++;
         $display("FAIL %s: circ_start still 0 after 100 cycles, expected 1", tag);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      mon_en = 1'b1;
      n_cmp++;
      if ({fill_start, circ_start, cmd_ready, busy} !== 4'b0011) begin
         n_err++;
         $display("FAIL reset_ctrl: got fs/cs/rdy/busy=%b, expected 0011",
                  {fill_start, circ_start, cmd_ready, busy});
      end
      n_cmp++;
      if ({VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT} !== 19'd0) begin
         n_err++;
         $display("FAIL reset_vga: got %h, expected 0", {VGA_X, VGA_Y, VGA_COLOUR, VGA_PLOT});
      end
      n_cmp++;
      if ({jobs_done, circ_cx, circ_cy, circ_r, circ_colour} !== 34'd0) begin
         n_err++;
         $display("FAIL reset_regs: got jobs=%0d job=%h, expected 0",
                  jobs_done, {circ_cx, circ_cy, circ_r, circ_colour});
      end
      rst = 1'b0;
      @(posedge clk); #2;
      n_cmp++;
      if (fill_start !== 1'b1) begin
         n_err++;
         $display("FAIL reset_autoclear: fill_start got %b, expected 1", fill_start);
      end
      wait_idle(fill_len + 100, "reset_clear_done");
      n_cmp++;
      if ({busy, VGA_PLOT, fill_start, jobs_done} !== 11'd0) begin
         n_err++;
         $display("FAIL reset_after_clear: busy=%b plot=%b fs=%b jobs=%0d, expected all 0",
                  busy, VGA_PLOT, fill_start, jobs_done);
      end
   endtask

   task automatic test_single_circle();
      job_t j;
      j = {8'd80, 7'd60, 8'd40, 3'b010};
      circ_stall = 1'b0;
      circ_len = 6;
      push_cmd(j);
      n_cmp++;
      if (circ_start !== 1'b0) begin
         n_err++;
         $display("FAIL single_early: circ_start got %b on accept edge, expected 0", circ_start);
      end
      @(posedge clk); #2;
      n_cmp++;
      if (circ_start !== 1'b1) begin
         n_err++;
         $display("FAIL single_start: circ_start got %b one edge after accept, expected 1", circ_start);
      end
      n_cmp++;
      if ({circ_cx, circ_cy, circ_r, circ_colour} !== j) begin
         n_err++;
         $display("FAIL single_job: got cx=%0d cy=%0d r=%0d col=%0d, expected 80 60 40 2",
                  circ_cx, circ_cy, circ_r, circ_colour);
      end
      wait_idle(200, "single_done");
      n_cmp++;
      if (jobs_done !== exp_jobs) begin
         n_err++;
         $display("FAIL single_jobs: jobs_done got %0d, expected %0d", jobs_done, exp_jobs);
      end
   endtask

   task automatic test_fifo_full();
      circ_stall = 1'b1;
      circ_len = 3;
      push_cmd(rand_job());
      wait_circ_start("full_first_start");
      for (int i = 0; i < 5; i++) push_cmd(rand_job());
      n_cmp++;
      if ({cmd_ready, busy} !== 2'b01) begin
         n_err++;
         $display("FAIL full_flags: ready/busy got %b, expected 01", {cmd_ready, busy});
      end
      circ_stall = 1'b0;
      wait_idle(500, "full_drain");
      n_cmp++;
      if (jobs_done !== exp_jobs || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL full_jobs: jobs_done got %0d (left %0d), expected %0d (left 0)",
                  jobs_done, exp_q.size(), exp_jobs);
      end
   endtask

   task automatic test_clear_during_draw();
      circ_stall = 1'b1;
      fill_len = 20;
      push_cmd(rand_job());
      wait_circ_start("cdd_first_start");
      push_cmd(rand_job());
      push_cmd(rand_job());
      @(negedge clk);
      clear_req = 1'b1;
      @(posedge clk); #1;
      clear_req = 1'b0;
      seq = "";
      repeat (3) @(negedge clk);
      circ_stall = 1'b0;
      wait_idle(1000, "cdd_drain");
      n_cmp++;
      if (seq != "FCC") begin
         n_err++;
         $display("FAIL cdd_order: engine starts got \"%s\", expected \"FCC\"", seq);
      end
      n_cmp++;
      if (jobs_done !== exp_jobs) begin
         n_err++;
         $display("FAIL cdd_jobs: jobs_done got %0d, expected %0d", jobs_done, exp_jobs);
      end
   endtask

   // A request held across the edge that launches a clear must not cause a second clear.
   task automatic test_clear_merge();
      seq = "";
      @(negedge clk);
      clear_req = 1'b1;
      repeat (2) @(posedge clk);
      #1 clear_req = 1'b0;
      wait_idle(500, "merge_done");
      n_cmp++;
      if (seq != "F") begin
         n_err++;
         $display("FAIL merge_clears: engine starts got \"%s\", expected \"F\"", seq);
      end
   endtask

   task automatic test_reset_mid_draw();
      circ_stall = 1'b1;
      push_cmd(rand_job());
      wait_circ_start("rmd_first_start");
      for (int i = 0; i < 3; i++) push_cmd(rand_job());
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #2;
      exp_q.delete();
      exp_jobs = 8'd0;
      n_cmp++;
      if ({circ_start, fill_start, cmd_ready, busy, VGA_PLOT} !== 5'b00110) begin
         n_err++;
         $display("FAIL rmd_abort: cs/fs/rdy/busy/plot got %b, expected 00110",
                  {circ_start, fill_start, cmd_ready, busy, VGA_PLOT});
      end
      n_cmp++;
      if (jobs_done !== 8'd0) begin
         n_err++;
         $display("FAIL rmd_jobs_reset: jobs_done got %0d, expected 0", jobs_done);
      end
      @(negedge clk);
      rst = 1'b0;
      circ_stall = 1'b0;
      seq = "";
      @(posedge clk); #2;
      n_cmp++;
      if (fill_start !== 1'b1) begin
         n_err++;
         $display("FAIL rmd_reclear: fill_start got %b, expected 1", fill_start);
      end
      wait_idle(500, "rmd_done");
      n_cmp++;
      if (seq != "F" || jobs_done !== 8'd0) begin
         n_err++;
         $display("FAIL rmd_flushed: starts \"%s\" jobs=%0d, expected \"F\" jobs=0", seq, jobs_done);
      end
   endtask

   task automatic test_jobs_wrap();
      for (int i = 0; i < 256; i++) begin
         circ_len = $urandom_range(0, 2);
         push_cmd(rand_job());
         wait_idle(100, "wrap_step");
         n_cmp++;
         if (jobs_done !== exp_jobs) begin
            n_err++;
            $display("FAIL wrap_count: jobs_done got %0d, expected %0d", jobs_done, exp_jobs);
         end
      end
      n_cmp++;
      if (jobs_done !== 8'd0) begin
         n_err++;
         $display("FAIL wrap_zero: jobs_done got %0d after 256 jobs, expected 0", jobs_done);
      end
   endtask

   task automatic test_random();
      job_t j;
      bit   exp_rdy;
      fill_len = 15;
      for (int c = 0; c < 600; c++) begin
         @(negedge clk);
         clear_req = ($urandom_range(0, 49) == 0);
         circ_len  = $urandom_range(0, 6);
         if ($urandom_range(0, 2) == 0) begin
            j = rand_job();
            cmd_valid = 1'b1;
            {cmd_cx, cmd_cy, cmd_r, cmd_colour} = j;
            exp_rdy = (exp_q.size() < QDEPTH);
            n_cmp++;
            if (cmd_ready !== exp_rdy) begin
               n_err++;
               $display("FAIL rand_ready: got %b, expected %b (queued %0d)", cmd_ready, exp_rdy, exp_q.size());
            end
            if (exp_rdy) begin
               exp_q.push_back(j);
               exp_jobs++;
            end
         end else begin
            cmd_valid = 1'b0;
         end
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      clear_req = 1'b0;
      wait_idle(5000, "rand_drain");
      n_cmp++;
      if (jobs_done !== exp_jobs || exp_q.size() != 0) begin
         n_err++;
         $display("FAIL rand_jobs: jobs_done got %0d (left %0d), expected %0d (left 0)",
                  jobs_done, exp_q.size(), exp_jobs);
      end
   endtask

   initial begin
      rst = 1'b1; cmd_valid = 1'b0; clear_req = 1'b0;
      cmd_cx = '0; cmd_cy = '0; cmd_r = '0; cmd_colour = '0;
      test_reset();
      test_single_circle();
      test_fifo_full();
      test_clear_during_draw();
      test_clear_merge();
      test_reset_mid_draw();
      test_jobs_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
